float_mult_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control and exception flags. It succeeds the fixed-format 3-stage multiplier. It adds run-time-independent format parameters, round-to-nearest-even, correct NaN/Inf/zero handling and backpressure. It sits between operand-issue logic and the result FIFO in the float datapath, and accepts one multiply per cycle when not stalled.

---
 rtl/float_pkg.sv | 20 ++
 rtl/float_round_rne.sv | 15 +
 rtl/float_mult_pipe.sv | 137 +++++++++++++
 tb/tb_float_mult_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// float_pkg: format defaults, operand classes, flag layout and per-format
// constants shared by the float datapath blocks.
package float_pkg;
   localparam int E_BIT_DEF = 8;
   localparam int F_BIT_DEF = 23;
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;
   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;
   function automatic int bias(input int e);
      return 2 ** (e - 1) - 1;
   endfunction
   function automatic int exp_ones(input int e);
      return 2 ** e - 1;
   endfunction
   function automatic logic [63:0] qnan(input int e, input int f);
      return (64'(exp_ones(e)) << f) | (64'd1 << (f - 1));
   endfunction
endpackage

// File: rtl/float_round_rne.sv
// float_round_rne: round-to-nearest-even of a normalised significand, given
// as its fraction bits (implicit leading one) plus guard/sticky.
module float_round_rne #(
   parameter int F_BIT = 23
) (
   input  logic [F_BIT-1:0] frac,
   input  logic             guard,
   input  logic             sticky,
   output logic [F_BIT-1:0] rnd,
   output logic             carry,
   output logic             inexact
);
   assign {carry, rnd} = {1'b0, frac} + {{F_BIT{1'b0}}, guard & (sticky | frac[0])};
   assign inexact = guard | sticky;
endmodule

// File: rtl/float_mult_pipe.sv
// float_mult_pipe: 3-stage floating-point multiplier, DAZ/FTZ, RNE rounding,
// valid/ready flow control with a global stall.
module float_mult_pipe
   import float_pkg::*;
#(
   parameter int E_BIT = E_BIT_DEF,
   parameter int F_BIT = F_BIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [E_BIT+F_BIT:0]   mul_a,
   input  logic [E_BIT+F_BIT:0]   mul_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [E_BIT+F_BIT:0]   out_a,
   output logic [3:0]             out_flags
);
   localparam int W = 1 + E_BIT + F_BIT;
   localparam int P = 2 * F_BIT + 2;
   localparam logic signed [E_BIT+1:0] BIAS = (E_BIT + 2)'(bias(E_BIT));
   localparam logic signed [E_BIT+1:0] EMAX = (E_BIT + 2)'(exp_ones(E_BIT));
   localparam logic [63:0] QN64 = qnan(E_BIT, F_BIT);
   localparam logic [W-1:0] QNAN = QN64[W-1:0];
   logic stall;
   logic sa, sb;
   logic [E_BIT-1:0] ea, eb;
   logic [F_BIT-1:0] fa, fb;
   cls_t ca, cb;
   logic nan0, snan0, ixz0, inf0, sinv0;
   logic [W-1:0] sres0;
   logic [P-1:0] ma, mb;
   logic v1, sgn1, spc1, sinv1;
   logic [W-1:0] sres1;
   logic [P-1:0] prod1;
   logic signed [E_BIT+1:0] exp1;
   logic msb1, grd1, stk1, cy1, inx1;
   logic [F_BIT-1:0] frac1, rnd1;
   logic v2, sgn2, spc2, sinv2, cy2, inx2, ovf2, unf2;
   logic [W-1:0] sres2, res2;
   logic [F_BIT-1:0] frac2;
   logic signed [E_BIT+1:0] exp2, e2;
   logic [3:0] flg2;
   assign stall = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign {sa, ea, fa} = mul_a;
   assign {sb, eb, fb} = mul_b;
   assign ca = ea == '0 ? CLS_ZERO : ea != '1 ? CLS_NORM : fa == '0 ? CLS_INF : CLS_NAN;
   assign cb = eb == '0 ? CLS_ZERO : eb != '1 ? CLS_NORM : fb == '0 ? CLS_INF : CLS_NAN;
   assign ma = {{(F_BIT+1){1'b0}}, 1'b1, fa};
   assign mb = {{(F_BIT+1){1'b0}}, 1'b1, fb};
   // Special-operand result resolved up front and carried as a bypass.
   always_comb begin
      nan0 = ca == CLS_NAN || cb == CLS_NAN;
      snan0 = (ca == CLS_NAN && !fa[F_BIT-1]) || (cb == CLS_NAN && !fb[F_BIT-1]);
      ixz0 = (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF);
      inf0 = ca == CLS_INF || cb == CLS_INF;
      sinv0 = nan0 ? snan0 : ixz0;
      sres0 = nan0 || ixz0 ? QNAN : inf0 ? {sa ^ sb, {E_BIT{1'b1}}, {F_BIT{1'b0}}} : {sa ^ sb, {(W-1){1'b0}}};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1 <= 1'b0;
         sgn1 <= 1'b0;
         spc1 <= 1'b0;
         sinv1 <= 1'b0;
         sres1 <= '0;
         prod1 <= '0;
         exp1 <= '0;
      end else if (!stall) begin
         v1 <= in_valid;
         sgn1 <= sa ^ sb;
         spc1 <= ca != CLS_NORM || cb != CLS_NORM;
         sinv1 <= sinv0;
         sres1 <= sres0;
         prod1 <= ma * mb;
         exp1 <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      end
   assign msb1 = prod1[P-1];
   assign frac1 = msb1 ? prod1[P-2:F_BIT+1] : prod1[P-3:F_BIT];
   assign grd1 = msb1 ? prod1[F_BIT] : prod1[F_BIT-1];
   assign stk1 = msb1 ? |prod1[F_BIT-1:0] : |prod1[F_BIT-2:0];
   float_round_rne #(.F_BIT(F_BIT)) u_rnd (
      .frac(frac1),
      .guard(grd1),
      .sticky(stk1),
      .rnd(rnd1),
      .carry(cy1),
      .inexact(inx1)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v2 <= 1'b0;
         sgn2 <= 1'b0;
         spc2 <= 1'b0;
         sinv2 <= 1'b0;
         sres2 <= '0;
         frac2 <= '0;
         cy2 <= 1'b0;
         inx2 <= 1'b0;
         exp2 <= '0;
      end else if (!stall) begin
         v2 <= v1;
         sgn2 <= sgn1;
         spc2 <= spc1;
         sinv2 <= sinv1;
         sres2 <= sres1;
         frac2 <= rnd1;
         cy2 <= cy1;
         inx2 <= inx1;
         exp2 <= exp1 + $signed({{(E_BIT+1){1'b0}}, msb1});
      end
   // A rounding carry leaves the fraction at zero, so only the exponent moves.
   assign e2 = exp2 + $signed({{(E_BIT+1){1'b0}}, cy2});
   assign ovf2 = e2 >= EMAX;
   assign unf2 = e2[E_BIT+1] || e2 == '0;
   assign res2 = spc2 ? sres2 : ovf2 ? {sgn2, {E_BIT{1'b1}}, {F_BIT{1'b0}}} :
                 unf2 ? {sgn2, {(W-1){1'b0}}} : {sgn2, e2[E_BIT-1:0], frac2};
   always_comb begin
      flg2 = '0;
      flg2[FLG_INV] = spc2 && sinv2;
      flg2[FLG_OVF] = !spc2 && ovf2;
      flg2[FLG_UNF] = !spc2 && !ovf2 && unf2;
      flg2[FLG_INX] = !spc2 && (ovf2 || unf2 || inx2);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_a <= '0;
         out_flags <= '0;
      end else if (!stall) begin
         out_valid <= v2;
         out_a <= res2;
         out_flags <= flg2;
      end
endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: scoreboard bench driving single- and half-precision
// instances with directed vectors, backpressure and mid-stream reset.
module tb_float_mult_pipe;
   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      int          t;
      bit          lat;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int got = 0;
   int hgot = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic iv, ir, ov, ordy;
   logic [31:0] a, b, oa;
   logic [3:0] of;
   logic hiv, hir, hov, hordy;
   logic [15:0] ha, hb, hoa;
   logic [3:0] hof;
   exp_t q[$];
   exp_t hq[$];
   logic [31:0] va[12] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3F800001,
                           32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000001,
                           32'h7F000000, 32'h00800000, 32'h7F800001, 32'h80000000};
   logic [31:0] vb[12] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h3FC00000,
                           32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000,
                           32'h40000000, 32'hBF000000, 32'h3F800000, 32'h40000000};
   logic [31:0] vr[12] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h3FC00002,
                           32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000,
                           32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h80000000};
   logic [3:0] vf[12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'h8, 4'h0};
   float_mult_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .mul_a(a), .mul_b(b),
      .out_valid(ov), .out_ready(ordy), .out_a(oa), .out_flags(of)
   );
   float_mult_pipe #(.E_BIT(5), .F_BIT(10)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(hiv), .in_ready(hir), .mul_a(ha), .mul_b(hb),
      .out_valid(hov), .out_ready(hordy), .out_a(hoa), .out_flags(hof)
   );
   task automatic chk(input string n, input logic [63:0] g, input logic [63:0] w);
      checks++;
      if (g !== w) begin
         failures++;
         $display("FAIL %s got=%h want=%h", n, g, w);
      end
   endtask
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                        input logic [3:0] f, input bit lat);
      int n = 0;
      iv = 1'b1; a = x; b = y;
      @(negedge clk);
      while (!ir && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (ir) q.push_back('{r, f, cyc, lat});
      else begin
         checks++;
         failures++;
         $display("FAIL issue_timeout in_ready=%b want=1", ir);
      end
      @(posedge clk);
      #1 iv = 1'b0;
   endtask
   task automatic hissue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] r,
                         input logic [3:0] f);
      int n = 0;
      hiv = 1'b1; ha = x; hb = y;
      @(negedge clk);
      while (!hir && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (hir) hq.push_back('{{16'h0, r}, f, cyc, 1'b1});
      else begin
         checks++;
         failures++;
         $display("FAIL hissue_timeout in_ready=%b want=1", hir);
      end
      @(posedge clk);
      #1 hiv = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || hq.size() != 0) && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("drain_left", 64'(q.size() + hq.size()), 0);
   endtask
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (ov && ordy) begin
            got++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_out got=%h want=none", oa);
            end else begin
               e = q.pop_front();
               chk("result", {oa, of}, {e.r, e.f});
               if (e.lat) chk("latency", 64'(cyc - e.t), 3);
            end
         end
         if (hov && hordy) begin
            hgot++;
            if (hq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_half got=%h want=none", hoa);
            end else begin
               e = hq.pop_front();
               chk("half_result", {hoa, hof}, {e.r[15:0], e.f});
               chk("half_latency", 64'(cyc - e.t), 3);
            end
         end
      end
   end
   initial begin
      int g0;
      iv = 0; a = 0; b = 0; ordy = 1;
      hiv = 0; ha = 0; hb = 0; hordy = 1;
      repeat (2) @(posedge clk);
      #1 chk("reset_state", {ov, ir, of, oa}, {1'b0, 1'b1, 4'h0, 32'h0});
      chk("reset_half", {hov, hir, hof, hoa}, {1'b0, 1'b1, 4'h0, 16'h0});
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) issue(va[i], vb[i], vr[i], vf[i], 1'b1);
      hissue(16'h3E00, 16'h4000, 16'h4200, 4'h0);
      hissue(16'h7BFF, 16'h4000, 16'h7C00, 4'h5);
      drain();
      g0 = got;
      ordy = 1'b0;
      fork
         for (int i = 0; i < 6; i++) issue(va[i], vb[i], vr[i], vf[i], 1'b0);
         begin
            repeat (4) @(negedge clk);
            chk("bp_in_ready", {ov, ir}, {1'b1, 1'b0});
            chk("bp_held", 64'(q.size()), 3);
            chk("bp_hold_a", {oa, of}, {q[0].r, q[0].f});
            repeat (3) @(negedge clk);
            chk("bp_stable_a", {oa, of}, {q[0].r, q[0].f});
            chk("bp_still_held", 64'(q.size()), 3);
            @(posedge clk);
            #1 ordy = 1'b1;
         end
      join
      drain();
      chk("bp_count", 64'(got - g0), 6);
      for (int i = 0; i < 3; i++) issue(va[i], vb[i], vr[i], vf[i], 1'b0);
      rst_n = 1'b0;
      #1 chk("rst_mid", {ov, of, oa}, {1'b0, 4'h0, 32'h0});
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      g0 = got;
      @(posedge clk);
      #1 issue(va[3], vb[3], vr[3], vf[3], 1'b1);
      repeat (8) @(posedge clk);
      #1 chk("rst_one_result", 64'(got - g0), 1);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
